// File: rtl/ifetch_queue.sv
// Instruction fetch front end. It issues single-word reads to the memory
// controller, predicts the next PC from each fetched word, and buffers
// {ins, pc, pred_pc} entries in a small FIFO that feeds the decoder.
// A ROB mispredict flush empties the FIFO, redirects the fetch PC and
// drops any read still in flight.
module ifetch_queue #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        flush_in,
   input  logic [31:0] flush_pc,
   output logic        decode_flag,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic [31:0] ins_pred_pc,
   input  logic        decode_ok
);

   localparam int               PTR_W    = $clog2(QUEUE_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t           state;
   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   // FIFO storage: data only, never reset; validity is tracked by count
   logic [31:0] ins_q  [QUEUE_DEPTH];
   logic [31:0] pc_q   [QUEUE_DEPTH];
   logic [31:0] pred_q [QUEUE_DEPTH];

   logic        not_empty;
   logic        push;
   logic        pop;
   logic [31:0] pred_next;

   // Static next-PC prediction: JAL and backward branches are taken,
   // everything else (JALR, forward branches, non-control) falls through.
   function automatic logic [31:0] predict_pc(input logic [31:0] pc,
                                              input logic [31:0] word);
      logic signed [31:0] j_imm;
      logic signed [31:0] b_imm;
      logic [31:0]        target;
      j_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
      b_imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
      if (word[6:0] == OP_JAL) begin
         target = $unsigned($signed(pc) + j_imm);
      end else if ((word[6:0] == OP_BRANCH) && word[31]) begin
         target = $unsigned($signed(pc) + b_imm);
      end else begin
         target = pc + 32'd4;
      end
      return target;
   endfunction

   assign not_empty   = (count != '0);
   assign decode_flag = not_empty && !flush_in;
   assign ins         = not_empty ? ins_q[head]  : 32'h0;
   assign ins_pc      = not_empty ? pc_q[head]   : 32'h0;
   assign ins_pred_pc = not_empty ? pred_q[head] : 32'h0;

   // A flush suppresses both FIFO ports; a push only completes a live read
   assign push      = (state == S_WAIT) && mem_done && !flush_in;
   assign pop       = decode_ok && decode_flag;
   assign pred_next = predict_pc(fetch_pc, mem_data);

   // Write the returned word and its prediction into the tail slot
   always_ff @(posedge clk_in) begin
      if (push) begin
         ins_q[tail]  <= mem_data;
         pc_q[tail]   <= fetch_pc;
         pred_q[tail] <= pred_next;
      end
   end

   // Fetch FSM plus FIFO pointers; flush overrides every other event
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= 32'h0;
      end else begin
         mem_req <= 1'b0;
         if (flush_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= flush_pc;
            case (state)
               S_WAIT:    state <= mem_done ? S_IDLE : S_DISCARD;
               S_DISCARD: state <= mem_done ? S_IDLE : S_DISCARD;
               default:   state <= S_IDLE;
            endcase
         end else begin
            if (push) begin
               tail <= tail + PTR_W'(1);
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
            case (state)
               S_IDLE: begin
                  // Only issue when a slot is guaranteed for the reply
                  if (count < FULL_CNT) begin
                     mem_req  <= 1'b1;
                     mem_addr <= fetch_pc;
                     state    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (mem_done) begin
                     fetch_pc <= pred_next;
                     state    <= S_IDLE;
                  end
               end
               S_DISCARD: begin
                  // Stale reply from before a flush: swallow it
                  if (mem_done) begin
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a responding memory with programmable latency,
// a queue-based reference model of the fetch queue checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_ifetch_queue;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;
   logic        flush_in;
   logic [31:0] flush_pc;
   logic        decode_flag;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic [31:0] ins_pred_pc;
   logic        decode_ok;

   ifetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk_in      (clk),
      .rst_in      (rst_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_done    (mem_done),
      .mem_data    (mem_data),
      .flush_in    (flush_in),
      .flush_pc    (flush_pc),
      .decode_flag (decode_flag),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .ins_pred_pc (ins_pred_pc),
      .decode_ok   (decode_ok)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // bench-side memory image and control
   logic [31:0] imem [logic [31:0]];
   int          lat    = 2;
   bit          pop_en = 1'b0;

   // reference model state
   ent_t        mq[$];
   logic [31:0] m_fetch = RST_PC;
   logic [31:0] m_addr  = 32'h0;
   bit          m_req   = 1'b0;
   bit          m_busy  = 1'b0;
   bit          m_drop  = 1'b0;

   // logs of observed DUT activity for the directed checks
   logic [31:0] req_log[$];
   ent_t        pop_log[$];
   int          first_done_cyc = -1;
   int          first_flag_cyc = -1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] rd(logic [31:0] a);
      if (imem.exists(a)) return imem[a];
      return 32'h00000013;
   endfunction

   // next PC from the instruction word, written as field-weighted sums
   function automatic logic [31:0] model_pred(logic [31:0] pc, logic [31:0] w);
      int imm;
      if (w[6:0] == 7'b1101111) begin
         imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
               - int'(w[31]) * 1048576;
         return pc + 32'(imm);
      end
      if (w[6:0] == 7'b1100011 && w[31]) begin
         imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
         return pc + 32'(imm);
      end
      return pc + 32'd4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_req(input string name, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=no mem_req required=mem_req within %0d cycles", name, max);
      end
   endtask

   // memory controller: latch each request, answer after lat cycles
   initial begin
      int          pend = 0;
      logic [31:0] paddr = 32'h0;
      mem_done = 1'b0;
      mem_data = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         mem_done = 1'b0;
         mem_data = 32'h0;
         if (!rst_n) begin
            pend = 0;
         end else begin
            if (mem_req) begin
               paddr = mem_addr;
               pend  = lat;
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  mem_done = 1'b1;
                  mem_data = rd(paddr);
               end
            end
         end
      end
   end

   // decoder: consume the head whenever allowed and enabled
   initial begin
      decode_ok = 1'b0;
      forever begin
         @(posedge clk);
         #4;
         decode_ok = pop_en && decode_flag;
      end
   end

   // reference model: updated from the inputs present at each rising edge
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_fetch = RST_PC;
            m_addr  = 32'h0;
            m_req   = 1'b0;
            m_busy  = 1'b0;
            m_drop  = 1'b0;
         end else begin
            int size_pre;
            size_pre = mq.size();
            m_req    = 1'b0;
            if (flush_in) begin
               mq.delete();
               m_fetch = flush_pc;
               if (m_busy && !mem_done) begin
                  m_drop = 1'b1;
               end else begin
                  m_busy = 1'b0;
                  m_drop = 1'b0;
               end
            end else begin
               if (decode_ok && mq.size() > 0) void'(mq.pop_front());
               if (m_busy && mem_done) begin
                  if (!m_drop) begin
                     mq.push_back('{mem_data, m_fetch, model_pred(m_fetch, mem_data)});
                     m_fetch = model_pred(m_fetch, mem_data);
                  end
                  m_busy = 1'b0;
                  m_drop = 1'b0;
               end else if (!m_busy && size_pre < DEPTH) begin
                  m_req  = 1'b1;
                  m_addr = m_fetch;
                  m_busy = 1'b1;
               end
            end
         end
         if (clk) cyc++;
      end
   end

   // every-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         ent_t h;
         @(negedge clk);
         h = (mq.size() > 0) ? mq[0] : '0;
         chk("mem_req", 32'(mem_req), 32'(m_req));
         chk("mem_addr", mem_addr, m_addr);
         chk("decode_flag", 32'(decode_flag), 32'((mq.size() != 0) && !flush_in));
         chk("ins", ins, h.ins);
         chk("ins_pc", ins_pc, h.pc);
         chk("ins_pred_pc", ins_pred_pc, h.pred);
         if (mem_req) req_log.push_back(mem_addr);
         if (decode_ok && decode_flag) pop_log.push_back('{ins, ins_pc, ins_pred_pc});
         if (mem_done && first_done_cyc < 0) first_done_cyc = cyc;
         if (decode_flag && first_flag_cyc < 0) first_flag_cyc = cyc;
      end
   end

   initial begin
      bit ok;
      int idx;
      rst_n    = 1'b0;
      flush_in = 1'b0;
      flush_pc = 32'h0;
      imem[32'h10]  = 32'h0080006F;
      imem[32'h20]  = 32'hFE000EE3;
      imem[32'h100] = 32'h00500093;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_decode_flag", 32'(decode_flag), 32'h0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      chk("rst_ins_pred_pc", ins_pred_pc, 32'h0);

      // first edge after release issues RESET_PC
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("req_before_edge", 32'(mem_req), 32'h0);
      tick();
      @(negedge clk);
      chk("first_req", 32'(mem_req), 32'h1);
      chk("first_addr", mem_addr, RST_PC);

      // decoder idle: fill exactly DEPTH entries, then stop requesting
      repeat (30) tick();
      @(negedge clk);
      chk("fill_req_count", 32'(req_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < req_log.size()) chk($sformatf("fill_addr%0d", i), req_log[i], 32'(4 * i));
      end
      chk("flag_latency", 32'(first_flag_cyc - first_done_cyc), 32'd1);
      chk("full_flag", 32'(decode_flag), 32'h1);
      chk("full_head_pc", ins_pc, 32'h0);
      chk("full_head_pred", ins_pred_pc, 32'h4);

      // one pop on a full queue -> exactly one new request a cycle later
      tick();
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      @(negedge clk);
      chk("req_after_pop_early", 32'(mem_req), 32'h0);
      tick();
      @(negedge clk);
      chk("req_after_pop", 32'(mem_req), 32'h1);
      chk("req_after_pop_addr", mem_addr, 32'h10);

      // drain continuously through the JAL and the backward branch
      pop_en = 1'b1;
      repeat (45) tick();
      idx = -1;
      foreach (pop_log[i]) if (idx < 0 && pop_log[i].ins == 32'h0080006F) idx = i;
      if (idx >= 0) begin
         chk("jal_pc", pop_log[idx].pc, 32'h10);
         chk("jal_pred", pop_log[idx].pred, 32'h18);
      end else chk("jal_seen", 32'h0, 32'h1);
      idx = -1;
      foreach (pop_log[i]) if (idx < 0 && pop_log[i].ins == 32'hFE000EE3) idx = i;
      if (idx >= 0) begin
         chk("beq_pc", pop_log[idx].pc, 32'h20);
         chk("beq_pred", pop_log[idx].pred, 32'h1C);
      end else chk("beq_seen", 32'h0, 32'h1);
      idx = -1;
      foreach (req_log[i]) if (idx < 0 && req_log[i] == 32'h10) idx = i;
      if (idx >= 0 && idx + 1 < req_log.size()) chk("addr_after_jal", req_log[idx + 1], 32'h18);
      else chk("addr_after_jal_seen", 32'h0, 32'h1);
      idx = -1;
      foreach (req_log[i]) if (idx < 0 && req_log[i] == 32'h20) idx = i;
      if (idx >= 0 && idx + 1 < req_log.size()) chk("addr_after_beq", req_log[idx + 1], 32'h1C);
      else chk("addr_after_beq_seen", 32'h0, 32'h1);

      // flush while waiting; the reply lands two cycles later and is dropped
      pop_en = 1'b0;
      lat    = 3;
      wait_req("flush_wait_req", 20, ok);
      flush_in = 1'b1;
      flush_pc = 32'h100;
      @(negedge clk);
      chk("flush_flag", 32'(decode_flag), 32'h0);
      tick();
      flush_in = 1'b0;
      flush_pc = 32'h0;
      tick();
      tick();
      @(negedge clk);
      chk("discard_flag", 32'(decode_flag), 32'h0);
      chk("discard_req", 32'(mem_req), 32'h0);
      wait_req("redirect_req", 10, ok);
      chk("redirect_addr", mem_addr, 32'h100);
      chk("redirect_flag", 32'(decode_flag), 32'h0);

      // flush coinciding with mem_done while two entries are queued
      lat = 2;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mq.size() == 2 && mem_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("flush_done_setup", 32'(ok), 32'h1);
      flush_in = 1'b1;
      flush_pc = 32'h200;
      @(negedge clk);
      chk("flush_done_flag", 32'(decode_flag), 32'h0);
      tick();
      flush_in = 1'b0;
      flush_pc = 32'h0;
      @(negedge clk);
      chk("flush_done_empty", 32'(decode_flag), 32'h0);
      chk("flush_done_ins", ins, 32'h0);
      chk("flush_done_pc", ins_pc, 32'h0);
      wait_req("flush_done_req", 10, ok);
      chk("flush_done_addr", mem_addr, 32'h200);

      // push and pop together at count 2 with the tail wrapping 3 -> 0
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mq.size() == 3 && !mem_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("pushpop_setup3", 32'(ok), 32'h1);
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mq.size() == 2 && mem_done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("pushpop_setup2", 32'(ok), 32'h1);
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      @(negedge clk);
      chk("pushpop_flag", 32'(decode_flag), 32'h1);
      chk("pushpop_head", ins_pc, 32'h208);
      tick();
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      @(negedge clk);
      chk("wrap_head", ins_pc, 32'h20C);
      pop_en = 1'b1;
      repeat (12) tick();

      // reset in the middle of a read
      pop_en = 1'b0;
      lat    = 4;
      wait_req("rst_wait_req", 20, ok);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req", 32'(mem_req), 32'h0);
      chk("midrst_addr", mem_addr, 32'h0);
      chk("midrst_flag", 32'(decode_flag), 32'h0);
      chk("midrst_ins_pc", ins_pc, 32'h0);
      tick();
      rst_n = 1'b1;
      wait_req("midrst_req_after", 5, ok);
      chk("midrst_restart_addr", mem_addr, RST_PC);
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // absolute guard so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: actual=still running required=finished");
      $fatal(1, "timeout");
   end

endmodule
